// File: rtl/secure_reg_arbiter.sv
// Round-robin arbitrated write controller for one protected register with ID-based access check.
// Optional violation logging (viol_cnt/viol_id) is enabled by defining SECURE_ARB_VIOL_LOG_EN.
module secure_reg_arbiter #(
    parameter int              N_REQ      = 4,
    parameter int              DATA_W     = 8,
    parameter int              ID_W       = 3,
    parameter logic [ID_W-1:0] ALLOWED_ID = ID_W'(4)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*ID_W-1:0]    req_id,
    input  logic [N_REQ*DATA_W-1:0]  req_data,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         deny,
    output logic [DATA_W-1:0]        reg_out,
`ifdef SECURE_ARB_VIOL_LOG_EN
    output logic [7:0]               viol_cnt,
    output logic [ID_W-1:0]          viol_id,
`endif
    output logic                     busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        COMMIT = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t              state_q;
    logic [IDX_W-1:0]    rr_ptr_q;
    logic [IDX_W-1:0]    idx_q;
    logic [ID_W-1:0]     id_q;
    logic [DATA_W-1:0]   data_q;
    logic                allow_q;
    logic [DATA_W-1:0]   reg_q;
    logic [N_REQ-1:0]    gnt_q;
    logic [N_REQ-1:0]    deny_q;
`ifdef SECURE_ARB_VIOL_LOG_EN
    logic [7:0]          viol_cnt_q;
    logic [ID_W-1:0]     viol_id_q;
`endif

    logic [ID_W-1:0]     id_arr   [N_REQ];
    logic [DATA_W-1:0]   data_arr [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign id_arr[gi]   = req_id[gi*ID_W +: ID_W];
            assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Round-robin search: candidate k is (rr_ptr + k) mod N_REQ, lowest k wins.
    logic               arb_valid_d;
    logic [IDX_W-1:0]   arb_idx_d;
    logic [IDX_W:0]     arb_sum;
    logic [IDX_W-1:0]   arb_cand;

    always_comb begin
        arb_valid_d = 1'b0;
        arb_idx_d   = '0;
        arb_sum     = '0;
        arb_cand    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            arb_sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (arb_sum >= (IDX_W+1)'(N_REQ)) begin
                arb_sum = arb_sum - (IDX_W+1)'(N_REQ);
            end
            arb_cand = arb_sum[IDX_W-1:0];
            if (!arb_valid_d && req[arb_cand]) begin
                arb_valid_d = 1'b1;
                arb_idx_d   = arb_cand;
            end
        end
    end

    logic [IDX_W-1:0]   rr_ptr_d;
    logic [N_REQ-1:0]   idx_onehot_d;

    always_comb begin
        rr_ptr_d     = (idx_q == IDX_W'(N_REQ-1)) ? '0 : idx_q + IDX_W'(1);
        idx_onehot_d = N_REQ'(1) << idx_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            idx_q      <= '0;
            id_q       <= '0;
            data_q     <= '0;
            allow_q    <= 1'b0;
            reg_q      <= '0;
            gnt_q      <= '0;
            deny_q     <= '0;
`ifdef SECURE_ARB_VIOL_LOG_EN
            viol_cnt_q <= '0;
            viol_id_q  <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (arb_valid_d) begin
                        idx_q   <= arb_idx_d;
                        id_q    <= id_arr[arb_idx_d];
                        data_q  <= data_arr[arb_idx_d];
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    // Decision is taken from the latched ID only; live req_id is ignored here.
                    allow_q <= (id_q == ALLOWED_ID);
                    state_q <= COMMIT;
                end
                COMMIT: begin
                    if (allow_q) begin
                        reg_q <= data_q;
                        gnt_q <= idx_onehot_d;
                    end else begin
                        deny_q <= idx_onehot_d;
`ifdef SECURE_ARB_VIOL_LOG_EN
                        viol_cnt_q <= (viol_cnt_q == 8'hFF) ? viol_cnt_q : viol_cnt_q + 8'd1;
                        viol_id_q  <= id_q;
`endif
                    end
                    rr_ptr_q <= rr_ptr_d;
                    state_q  <= RESP;
                end
                RESP: begin
                    gnt_q   <= '0;
                    deny_q  <= '0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign deny    = deny_q;
    assign reg_out = reg_q;
    assign busy    = (state_q != IDLE);
`ifdef SECURE_ARB_VIOL_LOG_EN
    assign viol_cnt = viol_cnt_q;
    assign viol_id  = viol_id_q;
`endif

endmodule

// File: doc/secure_reg_arbiter.md
# secure_reg_arbiter

Arbitrated, access-checked write controller for a single protected data register. Up to `N_REQ` requesters present a user ID and a data word; a round-robin arbiter selects one, checks its ID against the privileged ID, and either commits the word to the protected register or rejects it. The access decision and the register update always belong to the same latched transaction, so a stale or previous-cycle decision can never gate a write.

## Interface
- `N_REQ`, 4: number of requesters, 2..8
- `DATA_W`, 8: protected register width
- `ID_W`, 3: user ID width
- `ALLOWED_ID`, 3'h4: the only ID permitted to write
- `clk`  in  1  clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req`  in  N_REQ  per-requester write request, level, held until `gnt` or `deny`
- `req_id`  in  N_REQ*ID_W  packed IDs; requester i at bits [i*ID_W +: ID_W]
- `req_data`  in  N_REQ*DATA_W  packed write data, same packing
- `gnt`  out  N_REQ  one-hot, one-cycle pulse: the write was committed
- `deny`  out  N_REQ  one-hot, one-cycle pulse: the write was rejected
- `reg_out`  out  DATA_W  protected register contents
- `busy`  out  1  high whenever the FSM is not in IDLE

## Operation
- FSM states: IDLE, CHECK, COMMIT, RESP.
- IDLE: if `req` is nonzero, pick the winner by round-robin starting at pointer `rr_ptr`. Latch the winner index, `id_q`, and `data_q`, then go to CHECK. If `req` is zero, stay in IDLE.
- CHECK: register `allow_q = (id_q == ALLOWED_ID)`, then go to COMMIT. The check uses only `id_q`, never the live `req_id`.
- COMMIT: if `allow_q` is set, `reg_out <= data_q` and set `gnt[idx]`. Otherwise leave `reg_out` unchanged and set `deny[idx]`. Set `rr_ptr <= (idx+1) mod N_REQ` on both outcomes. Go to RESP.
- RESP: clear `gnt` and `deny`, then go to IDLE.
- `req`, `req_id` and `req_data` are ignored outside IDLE. A requester dropping `req` mid-transaction does not abort it; the pulse is still issued on the latched index.
- `gnt` and `deny` are never both nonzero, and at most one bit of either is set.
- `busy` is combinational from the state.
- Reset (asynchronous, at any point, including mid-transaction):
  - state = IDLE, `rr_ptr` = 0, `reg_out` = 0, `gnt` = 0, `deny` = 0, `allow_q` = 0, `id_q` = 0, `data_q` = 0.
  - An in-flight transaction is discarded with no pulse and no write.

## Timing
- Edge E0 (IDLE, `req` sampled) -> E1 CHECK -> E2 COMMIT. `reg_out` and the pulse are valid after E2, for one cycle. E3 returns to IDLE. The next arbitration samples at E4.
- Throughput: one transaction per 4 cycles while requests are pending.
- Handshake: a synchronous requester sees the pulse at E3 and deasserts `req` at E3. That requester is therefore not re-arbitrated at E4.
- Round-robin wrap: the pointer after index `N_REQ-1` is 0.
- A single persistent requester is served every 4 cycles.
- Requests that are simultaneous with the pointer are resolved with the pointer index first.

## Configuration
- `SECURE_ARB_VIOL_LOG_EN` defined: adds outputs `viol_cnt` (8 bits) and `viol_id` (ID_W bits).
  - On every deny in COMMIT, `viol_cnt` increments, saturating at 255, and `viol_id <= id_q`.
  - Both reset to 0. A grant does not change either.
- Not defined: these ports and their logic do not exist, and all other behaviour is identical.

## Test plan
- Reset -> `reg_out`=0, `gnt`=0, `deny`=0, `busy`=0. Then `req`=0001, id0=4, data0=0xA5 -> `gnt`=0001 two cycles after sampling, `reg_out`=0xA5.
- `req`=0010, id1=3, data1=0x3C, with `reg_out`=0xA5 -> `deny`=0010, `reg_out` stays 0xA5. With the log macro: `viol_cnt`=1, `viol_id`=3.
- All four requesters held with id=4 and data 0x10/0x11/0x12/0x13 -> grants in order 0,1,2,3, then 0 again, every 4 cycles. `reg_out` follows 0x10..0x13.
- Requester 2 has id=4 at the sampling edge and changes `req_id`=1 during CHECK -> still granted, because the decision uses the latched ID. The reverse case (id=1 latched, changed to 4 during CHECK) -> denied.
- `rst_n` asserted in COMMIT with an allowed request pending -> no pulse, `reg_out`=0. After release the FSM is IDLE and `rr_ptr`=0.
- With the log macro: 300 denied requests -> `viol_cnt` saturates at 255.
